// File: rtl/bcd_sub_serial_if.sv
// Operand/result bundle for the serial BCD subtractor; the master side issues
// operands and start, the slave side returns status and results.
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, neg, invalid
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor returning |a-b|, sign and an invalid flag.
// Latency DIGITS+1 (a>=b), 2*DIGITS+1 (a<b), 1 (invalid); start ignored while busy.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  bcd_sub_serial_if.slave   bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SUB, CPL, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q, r_q, diff_q;
  logic [3:0]     idx_q;
  logic           borrow_q, neg_q, bad_q;
  logic           done_q, neg_o, invalid_o;

  logic [3:0]     op_x, op_y, res;
  logic [4:0]     t;
  logic           borrow_out, last, in_bad;

  // In CPL the minuend is zero and the subtrahend is the working result.
  always_comb begin
    op_x = 4'd0;
    op_y = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == 4'(i)) begin
        op_x = (state == SUB) ? a_q[i*4 +: 4] : 4'd0;
        op_y = (state == SUB) ? b_q[i*4 +: 4] : r_q[i*4 +: 4];
      end
    end
  end

  always_comb begin
    t          = {1'b0, op_x} - {1'b0, op_y} - {4'd0, borrow_q};
    borrow_out = t[4];
    res        = borrow_out ? (t[3:0] + 4'd10) : t[3:0];
    last       = (idx_q == 4'(DIGITS - 1));
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a[i*4 +: 4] > 4'd9) || (bus.b[i*4 +: 4] > 4'd9)) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = in_bad ? DONE : SUB;
      SUB:  if (last) state_nxt = borrow_out ? CPL : DONE;
      CPL:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      idx_q     <= 4'd0;
      borrow_q  <= 1'b0;
      neg_q     <= 1'b0;
      bad_q     <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= '0;
      neg_o     <= 1'b0;
      invalid_o <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            r_q      <= '0;
            idx_q    <= 4'd0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            bad_q    <= in_bad;
          end
        end
        SUB, CPL: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 4'(i)) r_q[i*4 +: 4] <= res;
          end
          if (last) begin
            // Borrow out of the top digit means a<b: complement pass follows.
            idx_q    <= 4'd0;
            borrow_q <= 1'b0;
            if (state == SUB) neg_q <= borrow_out;
          end else begin
            idx_q    <= idx_q + 4'd1;
            borrow_q <= borrow_out;
          end
        end
        DONE: begin
          diff_q    <= bad_q ? '0 : r_q;
          neg_o     <= bad_q ? 1'b0 : neg_q;
          invalid_o <= bad_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_o;
  assign bus.invalid = invalid_o;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Bench for bcd_sub_serial: directed and random subtractions checked against an
// integer-arithmetic reference model.
module tb_bcd_sub_serial;
  localparam int D = 4;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  bcd_sub_serial_if #(.DIGITS(D)) bus ();

  bcd_sub_serial #(.DIGITS(D)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                output logic [15:0] d, output logic n,
                                output logic inv, output int lat);
    int x, y, m;
    logic [3:0] da, db;
    x = 0; y = 0; inv = 1'b0; d = '0; n = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      da = av[i*4 +: 4];
      db = bv[i*4 +: 4];
      if (da > 4'd9 || db > 4'd9) inv = 1'b1;
      x = x * 10 + int'(da);
      y = y * 10 + int'(db);
    end
    if (inv) begin
      lat = 1;
      return;
    end
    m = x - y;
    n = (m < 0);
    if (n) m = -m;
    for (int i = 0; i < D; i++) begin
      d[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    lat = n ? 2 * D + 1 : D + 1;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < D; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Issues one operation and returns what the DUT reported (lat=-1 on timeout).
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, output int lat,
                       output logic [15:0] d, output logic n, output logic inv);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    d = bus.diff;
    n = bus.neg;
    inv = bus.invalid;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #3;
    checks++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_status: ready/busy/done=%b required 100", {bus.ready, bus.busy, bus.done});
    end
    checks++;
    if ({bus.diff, bus.neg, bus.invalid} !== 18'd0) begin
      failures++;
      $display("FAIL reset_results: diff=%h neg=%b invalid=%b required 0", bus.diff, bus.neg, bus.invalid);
    end
    #19 n_rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'h0567, 16'h0000, 16'h5000, 16'h9999};
    logic [15:0] tb [5] = '{16'h0567, 16'h1234, 16'h0001, 16'h5000, 16'h0000};
    logic [15:0] td [5] = '{16'h0667, 16'h0667, 16'h0001, 16'h0000, 16'h9999};
    logic        tn [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int          tl [5] = '{5, 9, 9, 5, 5};
    int lat;
    logic [15:0] d;
    logic n, inv;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], lat, d, n, inv);
      checks++;
      if (lat !== tl[i]) begin
        failures++;
        $display("FAIL directed_latency %h-%h: got %0d edges required %0d", ta[i], tb[i], lat, tl[i]);
      end
      checks++;
      if ({d, n, inv} !== {td[i], tn[i], 1'b0}) begin
        failures++;
        $display("FAIL directed_result %h-%h: diff=%h neg=%b inv=%b required diff=%h neg=%b inv=0",
                 ta[i], tb[i], d, n, inv, td[i], tn[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.diff !== td[i]) begin
        failures++;
        $display("FAIL directed_pulse_hold: done=%b diff=%h required done=0 diff=%h", bus.done, bus.diff, td[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int lat;
    logic [15:0] d;
    logic n, inv;
    do_op(16'h12A4, 16'h0001, lat, d, n, inv);
    checks++;
    if (lat !== 1 || {d, n, inv} !== {16'h0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL invalid_path: lat=%0d diff=%h neg=%b inv=%b required lat=1 diff=0000 neg=0 inv=1",
               lat, d, n, inv);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [15:0] av, bv, d, ed;
    logic n, inv, en, einv;
    for (int i = 0; i < 40; i++) begin
      av = rand_bcd();
      bv = ($urandom_range(0, 7) == 0) ? av : rand_bcd();
      if ($urandom_range(0, 9) == 0) av[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      model(av, bv, ed, en, einv, elat);
      do_op(av, bv, lat, d, n, inv);
      checks++;
      if (lat !== elat || {d, n, inv} !== {ed, en, einv}) begin
        failures++;
        $display("FAIL random %h-%h: lat=%0d diff=%h neg=%b inv=%b required lat=%0d diff=%h neg=%b inv=%b",
                 av, bv, lat, d, n, inv, elat, ed, en, einv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa[$], qb[$];
    logic [15:0] last_diff, pa, pb, ed;
    logic en, einv;
    int elat, accepts, dones;
    accepts = 0;
    dones = 0;
    last_diff = bus.diff;
    for (int it = 0; it < 150; it++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_done: done with no pending start");
        end else begin
          pa = qa.pop_front();
          pb = qb.pop_front();
          model(pa, pb, ed, en, einv, elat);
          if ({bus.diff, bus.neg, bus.invalid} !== {ed, en, einv}) begin
            failures++;
            $display("FAIL b2b_result %h-%h: diff=%h neg=%b inv=%b required diff=%h neg=%b inv=%b",
                     pa, pb, bus.diff, bus.neg, bus.invalid, ed, en, einv);
          end
        end
        last_diff = bus.diff;
      end else if (bus.diff !== last_diff) begin
        checks++;
        failures++;
        $display("FAIL b2b_diff_stable: diff=%h required %h", bus.diff, last_diff);
      end
      @(negedge clk);
      if (it < 110) begin
        bus.a = rand_bcd();
        bus.b = rand_bcd();
        bus.start = 1'b1;
        if (bus.ready) begin
          qa.push_back(bus.a);
          qb.push_back(bus.b);
          accepts++;
        end
      end else begin
        bus.start = 1'b0;
      end
    end
    checks++;
    if (dones !== accepts || qa.size() != 0 || accepts < 8) begin
      failures++;
      $display("FAIL b2b_count: dones=%0d required accepts=%0d (pending %0d)", dones, accepts, qa.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat, elat, dseen;
    logic [15:0] d, ed;
    logic n, inv, en, einv;
    @(negedge clk);
    bus.a = 16'h1234;
    bus.b = 16'h0567;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.busy, bus.done, bus.diff, bus.neg, bus.invalid} !== {3'b100, 18'd0}) begin
      failures++;
      $display("FAIL midreset_outputs: ready=%b busy=%b done=%b diff=%h neg=%b inv=%b required 1,0,0,0,0,0",
               bus.ready, bus.busy, bus.done, bus.diff, bus.neg, bus.invalid);
    end
    dseen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dseen++;
      if (k == 2) n_rst = 1'b1;
    end
    checks++;
    if (dseen !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: saw %0d done pulses required 0", dseen);
    end
    model(16'h4321, 16'h1111, ed, en, einv, elat);
    do_op(16'h4321, 16'h1111, lat, d, n, inv);
    checks++;
    if (lat !== elat || {d, n, inv} !== {ed, en, einv}) begin
      failures++;
      $display("FAIL midreset_restart: lat=%0d diff=%h neg=%b required lat=%0d diff=%h neg=%b",
               lat, d, n, elat, ed, en);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_invalid();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_sub_serial.md
BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4, the number of packed BCD digits per operand (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled only when ready=1.
REQ-005 SHALL have port a, input, 4*DIGITS, minuend as packed BCD; digit 0 in [3:0].
REQ-006 SHALL have port b, input, 4*DIGITS, subtrahend as packed BCD.
REQ-007 SHALL have port ready, output, 1, high only in IDLE.
REQ-008 SHALL have port busy, output, 1, logical inverse of ready.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking that diff/neg/invalid are updated.
REQ-010 SHALL have port diff, output, 4*DIGITS, magnitude of a-b as packed BCD.
REQ-011 SHALL have port neg, output, 1, high when a<b.
REQ-012 SHALL have port invalid, output, 1, high when any digit of the latched a or b exceeds 9.

Function
REQ-013 SHALL implement states IDLE, SUB, CPL and DONE.
REQ-014 SHALL, in IDLE with start=1 at a clock edge, latch a and b, clear borrow and the digit index, and set the working result to 0.
REQ-015 SHALL, on that same edge, go to DONE if any latched digit exceeds 9; otherwise it SHALL go to SUB.
REQ-016 SHALL, in SUB, process one digit per cycle from digit 0 upward.
  - Each SUB cycle computes t = a_i - b_i - borrow.
  - If t<0, it stores t+10 and sets borrow=1.
  - Otherwise it stores t and clears borrow.
REQ-017 SHALL, after exactly DIGITS SUB cycles, go to DONE if the final borrow is 0, or go to CPL if the final borrow is 1.
REQ-018 SHALL, on entry to CPL, clear borrow and the digit index.
  - Each CPL cycle replaces working digit i with 0 - r_i - borrow, using the same +10 and borrow rule as SUB.
  - This produces the ten's complement of the working result.
  - The block leaves CPL for DONE after exactly DIGITS cycles.
REQ-019 SHALL, in DONE, hold done=1 for one cycle, update diff, neg and invalid together, and go to IDLE on the next edge.
REQ-020 SHALL hold diff, neg and invalid stable from one done pulse until the next done pulse.
REQ-021 SHALL ignore start whenever ready=0, including in DONE, with no effect on the operation in progress.
REQ-022 SHALL take a and b into account only on the accepting edge; changes during SUB or CPL SHALL have no effect.
REQ-023 SHALL, on the invalid path, report invalid=1, diff=0 and neg=0.
REQ-024 SHALL report neg=0 whenever the result is 0, including a=b.
REQ-025 SHALL raise done at the following edge counts after the accepting edge:
  - DIGITS+1 edges when a>=b;
  - 2*DIGITS+1 edges when a<b;
  - 1 edge on the invalid path.
REQ-026 SHALL produce only BCD digits 0..9 in diff on every valid path.

Reset
REQ-027 SHALL, while n_rst=0, force state to IDLE and hold ready=1, busy=0, done=0, diff=0, neg=0 and invalid=0, independent of clk.
REQ-028 SHALL, on n_rst assertion mid-operation, abandon the operation with no done pulse, and SHALL accept a new start on the first clock edge after release.

Verification
REQ-029 SHALL have a bench case with DIGITS=4, a=0x1234, b=0x0567, start pulsed: done 5 edges later with diff=0x0667, neg=0, invalid=0.
REQ-030 SHALL have a bench case with a=0x0567, b=0x1234: done 9 edges later with diff=0x0667, neg=1; also a=0x0000, b=0x0001 giving diff=0x0001, neg=1.
REQ-031 SHALL have a bench case with a=0x5000, b=0x5000 giving diff=0x0000, neg=0, and a=0x9999, b=0x0000 giving diff=0x9999, neg=0.
REQ-032 SHALL have a bench case with a=0x12A4, b=0x0001: done 1 edge later with invalid=1, diff=0x0000, neg=0.
REQ-033 SHALL have a bench case where start=1 is held continuously and a, b change during SUB: exactly one done per accepted start, and results match the operands present at the accepting edge.
REQ-034 SHALL have a bench case asserting n_rst during the third SUB cycle: all outputs 0, ready=1, no done pulse; a start after release completes normally.
